// File: rtl/turn_arbiter.sv
// Two-player turn controller driving a shared 2-bit accumulator: legality check, step strobe, win detect.
// Optional per-turn idle forfeit is built only when TURN_TIMEOUT_EN is defined.
module turn_arbiter #(
    parameter int TARGET      = 3,
    parameter int TIMEOUT_CYC = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       p0_req,
    input  logic [1:0] p0_num,
    input  logic       p1_req,
    input  logic [1:0] p1_num,
    input  logic       restart,
    input  logic [1:0] acc_value,
    output logic [1:0] acc_num,
    output logic       acc_step,
    output logic       acc_clear,
    output logic       turn,
    output logic       illegal,
    output logic       game_over,
    output logic       winner
);

    typedef enum logic [2:0] {CLEAR, WAIT, STEP, SETTLE, CHECK, DONE} state_t;

    state_t     state;
    logic       p0_prev, p1_prev, restart_prev;
    logic       p0_edge, p1_edge, restart_edge;
    logic       req_edge;
    logic [1:0] req_num;
    logic [2:0] sum;
    logic       legal;
    logic       timeout;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p0_prev      <= 1'b0;
            p1_prev      <= 1'b0;
            restart_prev <= 1'b0;
        end else begin
            p0_prev      <= p0_req;
            p1_prev      <= p1_req;
            restart_prev <= restart;
        end
    end

    assign p0_edge      = p0_req & ~p0_prev;
    assign p1_edge      = p1_req & ~p1_prev;
    assign restart_edge = restart & ~restart_prev;

    // Only the player whose turn it is gets heard; the other edge is dropped silently.
    assign req_edge = turn ? p1_edge : p0_edge;
    assign req_num  = turn ? p1_num : p0_num;
    assign sum      = {1'b0, acc_value} + {1'b0, req_num};
    assign legal    = (req_num != 2'd0) && (sum <= 3'(TARGET));

`ifdef TURN_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CW-1:0] idle_cnt;

    assign timeout = (state == WAIT) && (idle_cnt == CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt <= '0;
        end else if (state != WAIT || restart_edge || req_edge || timeout) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;

    if (TIMEOUT_CYC < 1) begin : g_timeout_unused
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= CLEAR;
            acc_num   <= 2'd0;
            acc_step  <= 1'b0;
            acc_clear <= 1'b0;
            turn      <= 1'b0;
            illegal   <= 1'b0;
            game_over <= 1'b0;
            winner    <= 1'b0;
        end else begin
            acc_step  <= 1'b0;
            acc_clear <= 1'b0;
            illegal   <= 1'b0;
            if (restart_edge) begin
                state     <= CLEAR;
                acc_clear <= 1'b1;
            end else begin
                case (state)
                    // Coming out of reset the clear strobe is not yet up, so raise it here first.
                    CLEAR: begin
                        turn      <= 1'b0;
                        acc_num   <= 2'd0;
                        game_over <= 1'b0;
                        winner    <= 1'b0;
                        if (acc_clear) begin
                            state <= WAIT;
                        end else begin
                            acc_clear <= 1'b1;
                        end
                    end
                    WAIT: begin
                        if (req_edge) begin
                            if (legal) begin
                                acc_num  <= req_num;
                                acc_step <= 1'b1;
                                state    <= STEP;
                            end else begin
                                illegal <= 1'b1;
                            end
                        end else if (timeout) begin
                            turn <= ~turn;
                        end
                    end
                    STEP:   state <= SETTLE;
                    SETTLE: state <= CHECK;
                    CHECK: begin
                        if (acc_value == 2'(TARGET)) begin
                            game_over <= 1'b1;
                            winner    <= turn;
                            state     <= DONE;
                        end else begin
                            turn  <= ~turn;
                            state <= WAIT;
                        end
                    end
                    DONE:    state <= DONE;
                    default: state <= CLEAR;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_turn_arbiter.sv
// Self-checking bench for turn_arbiter: game-rule reference model, model accumulator, random moves.
module tb_turn_arbiter;

    localparam int TGT = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       p0_req = 1'b0;
    logic [1:0] p0_num = 2'd0;
    logic       p1_req = 1'b0;
    logic [1:0] p1_num = 2'd0;
    logic       restart = 1'b0;
    logic [1:0] acc_value;
    logic [1:0] acc_num;
    logic       acc_step, acc_clear, turn, illegal, game_over, winner;

    int total = 0;
    int bad = 0;

    int m_acc = 0;
    bit m_turn = 1'b0;
    bit m_over = 1'b0;
    bit m_winner = 1'b0;

    turn_arbiter #(.TARGET(TGT), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_num(p0_num),
        .p1_req(p1_req), .p1_num(p1_num),
        .restart(restart), .acc_value(acc_value),
        .acc_num(acc_num), .acc_step(acc_step), .acc_clear(acc_clear),
        .turn(turn), .illegal(illegal), .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    // Model accumulator: adds the operand when the step strobe falls at a clock edge.
    always @(posedge clk or posedge reset) begin
        if (reset) acc_value <= 2'd0;
        else if (acc_clear) acc_value <= 2'd0;
        else if (acc_step) acc_value <= acc_value + acc_num;
    end

    initial begin
        #500_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_acc = 0;
        m_turn = 1'b0;
        m_over = 1'b0;
        m_winner = 1'b0;
    endtask

    task automatic resetAndCheck();
        int clears;
        reset = 1'b1;
        p0_req = 1'b0;
        p1_req = 1'b0;
        restart = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        checkOutput("rst_acc_num", acc_num, 0);
        checkOutput("rst_acc_step", acc_step, 0);
        checkOutput("rst_acc_clear", acc_clear, 0);
        checkOutput("rst_turn", turn, 0);
        checkOutput("rst_illegal", illegal, 0);
        checkOutput("rst_game_over", game_over, 0);
        checkOutput("rst_winner", winner, 0);
        clears = 0;
        repeat (5) begin
            tick();
            clears += int'(acc_clear);
        end
        checkOutput("rst_clear_pulses", clears, 1);
        modelReset();
    endtask

    task automatic restartGame();
        restart = 1'b1;
        tick();
        checkOutput("rs_acc_clear", acc_clear, 1);
        restart = 1'b0;
        tick();
        checkOutput("rs_clear_done", acc_clear, 0);
        checkOutput("rs_turn", turn, 0);
        checkOutput("rs_game_over", game_over, 0);
        checkOutput("rs_acc_num", acc_num, 0);
        checkOutput("rs_acc_value", acc_value, 0);
        modelReset();
        tick();
    endtask

    // One move attempt: predict its outcome from the game rules, then follow the n+1..n+4 timeline.
    task automatic applyStimulus(input bit e0, input bit e1, input logic [1:0] n0, input logic [1:0] n1);
        int num;
        bit exp_step;
        bit exp_ill;
        num = 0;
        exp_step = 1'b0;
        exp_ill = 1'b0;
        if (!m_over && (m_turn ? e1 : e0)) begin
            num = m_turn ? int'(n1) : int'(n0);
            if (num == 0 || m_acc + num > TGT) begin
                exp_ill = 1'b1;
            end else begin
                exp_step = 1'b1;
                m_acc += num;
                if (m_acc == TGT) begin
                    m_over = 1'b1;
                    m_winner = m_turn;
                end else begin
                    m_turn = ~m_turn;
                end
            end
        end
        p0_num = n0;
        p1_num = n1;
        p0_req = e0;
        p1_req = e1;
        tick();
        checkOutput("mv_step", acc_step, exp_step);
        checkOutput("mv_illegal", illegal, exp_ill);
        if (exp_step) checkOutput("mv_acc_num", acc_num, num);
        p0_req = 1'b0;
        p1_req = 1'b0;
        tick();
        checkOutput("mv_step_low", acc_step, 0);
        checkOutput("mv_illegal_low", illegal, 0);
        tick();
        tick();
        checkOutput("mv_turn", turn, m_turn);
        checkOutput("mv_game_over", game_over, m_over);
        if (m_over) checkOutput("mv_winner", winner, m_winner);
        checkOutput("mv_acc_value", acc_value, m_acc);
        tick();
    endtask

    task automatic restartInSettle();
        p0_num = 2'd1;
        p0_req = 1'b1;
        tick();
        checkOutput("rsettle_step", acc_step, 1);
        p0_req = 1'b0;
        tick();
        restart = 1'b1;
        tick();
        checkOutput("rsettle_clear", acc_clear, 1);
        checkOutput("rsettle_step_low", acc_step, 0);
        restart = 1'b0;
        tick();
        checkOutput("rsettle_turn", turn, 0);
        checkOutput("rsettle_over", game_over, 0);
        checkOutput("rsettle_acc", acc_value, 0);
        modelReset();
        tick();
    endtask

    initial begin
        resetAndCheck();
`ifdef TURN_TIMEOUT_EN
        begin
            int last;
            int toggles;
            int steps;
            bit prev_turn;
            last = -1;
            toggles = 0;
            steps = 0;
            prev_turn = turn;
            for (int c = 0; c < 60; c++) begin
                tick();
                steps += int'(acc_step);
                if (turn != prev_turn) begin
                    if (last >= 0) checkOutput("timeout_period", c - last, 8);
                    last = c;
                    toggles++;
                end
                prev_turn = turn;
            end
            checkOutput("timeout_seen", toggles >= 6, 1);
            checkOutput("timeout_no_step", steps, 0);
        end
`else
        applyStimulus(1'b1, 1'b0, 2'd1, 2'd0);
        applyStimulus(1'b0, 1'b1, 2'd0, 2'd2);
        restartGame();
        applyStimulus(1'b1, 1'b0, 2'd1, 2'd0);
        applyStimulus(1'b0, 1'b1, 2'd0, 2'd1);
        applyStimulus(1'b1, 1'b0, 2'd2, 2'd0);
        applyStimulus(1'b1, 1'b0, 2'd0, 2'd0);
        applyStimulus(1'b0, 1'b1, 2'd0, 2'd1);
        applyStimulus(1'b1, 1'b1, 2'd1, 2'd2);
        restartGame();
        restartInSettle();

        p0_num = 2'd1;
        p0_req = 1'b1;
        tick();
        checkOutput("async_step_before", acc_step, 1);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_step_cleared", acc_step, 0);
        checkOutput("async_acc_num", acc_num, 0);
        resetAndCheck();

        begin
            int idle_bad;
            idle_bad = 0;
            repeat (100) begin
                tick();
                if (turn !== 1'b0 || acc_step !== 1'b0) idle_bad++;
            end
            checkOutput("idle_turn_hold", idle_bad, 0);
        end

        for (int i = 0; i < 80; i++) begin
            int r;
            if ((m_over && $urandom_range(0, 2) == 0) || $urandom_range(0, 14) == 0) begin
                restartGame();
            end else begin
                r = $urandom_range(0, 9);
                applyStimulus(r <= 3 || r >= 8, r >= 4,
                              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            end
        end
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/turn_arbiter.md
# turn_arbiter

Two-player turn controller that shares the 2-bit accumulator datapath between two requesters. Detects each player's move request, checks legality against the current accumulated value, and issues a single step strobe with the operand to the accumulator. Reads back the result, alternates turns and declares a winner when the target is reached. Sits between the debounced button/switch inputs and the accumulator/adder pair in the FPGA controller.

## Interface
- `TARGET`, 3: winning accumulated value. Range 1..3; the accumulator is 2-bit.
- `TIMEOUT_CYC`, 50_000_000: per-turn idle limit in `clk` cycles. Used only with `TURN_TIMEOUT_EN`.
- `clk` in 1: system clock.
- `reset` in 1: one clock; reset is asynchronous and active-high.
- `p0_req` in 1: player 0 move request, debounced level. A rising edge is one request.
- `p0_num` in 2: player 0 operand, sampled on the `p0_req` rising edge.
- `p1_req` in 1: player 1 move request, debounced level.
- `p1_num` in 2: player 1 operand.
- `restart` in 1: new-game request, debounced level, rising edge.
- `acc_value` in 2: current accumulator output.
- `acc_num` out 2: operand presented to the accumulator.
- `acc_step` out 1: one-cycle step strobe. The accumulator adds `acc_num` on its falling edge.
- `acc_clear` out 1: one-cycle clear strobe to the accumulator.
- `turn` out 1: player whose move is expected (0/1).
- `illegal` out 1: one-cycle pulse when a move by the current player is rejected.
- `game_over` out 1: high from win until the game is cleared.
- `winner` out 1: player who reached `TARGET`. Valid while `game_over` is high.

## Operation
- Rising edges of `p0_req`, `p1_req` and `restart` are detected by registering the previous level. Inputs are already synchronous and debounced.
- States:
  - CLEAR: `acc_clear`=1 for one cycle, `turn`←0, then go to WAIT.
  - WAIT: accept an edge only from player `turn`. Edges from the other player are ignored silently, with no `illegal` pulse.
  - STEP: `acc_step`=1, `acc_num` held at the latched operand.
  - SETTLE: `acc_step`=0. The accumulator updates at this edge.
  - CHECK: if `acc_value`==`TARGET`, set `game_over`=1, set `winner`=`turn`, go to DONE. Otherwise toggle `turn` and go to WAIT.
  - DONE: wait for a `restart` edge, then go to CLEAR.
- Legality in WAIT: the move is legal iff `num`≠0 and `acc_value`+`num` ≤ `TARGET`, computed 3 bits wide with no wrap. An illegal move pulses `illegal` for one cycle, keeps the same `turn` and stays in WAIT.
- `acc_num` holds the last legal operand between moves and is 0 after reset/CLEAR.
- A `restart` edge in any state other than DONE goes to CLEAR. This abandons the game in progress, including mid STEP/SETTLE.
- If both players' edges arrive in the same cycle, only the edge from player `turn` is considered.

## Timing
- Reset values: `acc_num`=0, `acc_step`=0, `acc_clear`=0, `turn`=0, `illegal`=0, `game_over`=0, `winner`=0. The state is CLEAR, so `acc_clear` pulses in the first cycle after reset deassertion.
- All outputs are registered.
- Legal request edge seen in WAIT at cycle n:
  - `acc_step`=1 at n+1.
  - SETTLE at n+2.
  - CHECK samples `acc_value` at n+3.
  - `turn` toggle or `game_over` visible at n+4.
- Minimum spacing between accepted moves is 4 cycles. Edges arriving outside WAIT are dropped and never queued.
- An `illegal` pulse is visible at n+1.
- `restart` edge at cycle n: `acc_clear`=1 at n+1, and WAIT with `turn`=0 at n+2.
- Asynchronous `reset` mid-move clears the state immediately. Any `acc_step` in flight is deasserted.

## Configuration
- `TURN_TIMEOUT_EN` defined:
  - A counter runs in WAIT, cleared on entry to WAIT and on an illegal attempt.
  - Reaching `TIMEOUT_CYC`-1 forfeits the turn: `turn` toggles, the accumulator is untouched, the counter clears and the state stays in WAIT.
  - The counter is held at 0 in all other states.
- `TURN_TIMEOUT_EN` undefined: no counter is built. `TIMEOUT_CYC` is unused and a turn waits indefinitely.

## Test plan
- Reset release → `acc_clear` high exactly one cycle; `turn`=0, `game_over`=0, `acc_num`=0.
- With `TARGET`=3 and a model accumulator: p0 num=1, then p1 num=2 → `acc_step` pulses twice with `acc_num` 1 then 2; after CHECK, `game_over`=1 and `winner`=1.
- `acc_value`=2, p0 num=2 (sum 4 > 3) → `illegal` one-cycle pulse, no `acc_step`, `turn` stays 0. Also p0 num=0 → `illegal` pulse.
- p1 edge while `turn`=0 → no `acc_step`, no `illegal`. Simultaneous p0/p1 edges with `turn`=0 → only p0's operand is applied.
- `restart` edge in SETTLE → CLEAR, `acc_clear` pulse, `turn`=0. Then in DONE, `restart` → new game starts from `acc_value`=0.
- `TURN_TIMEOUT_EN` with `TIMEOUT_CYC`=8, no input → `turn` toggles every 8 cycles in WAIT and `acc_step` never asserts. Without the macro → `turn` remains 0 for 100 cycles.
